// File: rtl/dot_product_ctrl.sv
// dot_product_ctrl
//   Sequencing stage around the 8x8 start/ready sequential multiplier.
//   Operand pairs arrive on a valid/ready stream. Each pair is handed to
//   the multiplier. LEN products are summed into one unsigned result,
//   which is offered on a valid/ready output.
//
//   Build option: DOT_PRODUCT_SATURATE_EN
//     defined   - accumulator saturates to all-ones on carry out, and ovf is
//                 sticky until the result is accepted, clr, or reset
//     undefined - accumulator wraps modulo 2^ACC_W, and ovf is tied low
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   clr                  synchronous abort back to IDLE
//   in_valid/in_ready    operand pair handshake, in_a/in_b operands
//   mul_a/mul_b          registered multiplier operands
//   mul_start            one-cycle multiplier start pulse
//   mul_ready/mul_m      multiplier done flag and product
//   sum/sum_valid        dot-product result and its valid flag
//   sum_ready            downstream accept
//   ovf                  overflow flag for the current result
//
// state | meaning
// IDLE  | ready for the next operand pair
// START | mul_start asserted for this one cycle
// WAIT  | waiting on mul_ready, accumulate when it arrives
// DONE  | result presented, waiting for sum_ready
module dot_product_ctrl #(
  parameter int W     = 8,
  parameter int LEN   = 4,
  parameter int ACC_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  output logic             mul_start,
  input  logic             mul_ready,
  input  logic [2*W-1:0]   mul_m,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             ovf
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] mul_ext;
  logic [ACC_W-1:0] acc_next;
  logic             last;

  assign mul_ext = ACC_W'(mul_m);
  assign last    = (cnt == CNT_W'(LEN - 1));

`ifdef DOT_PRODUCT_SATURATE_EN
  logic [ACC_W:0] add_full;
  logic           carry;

  assign add_full = {1'b0, acc} + {1'b0, mul_ext};
  assign carry    = add_full[ACC_W];
  // once saturated, stay at all-ones for the rest of the vector
  assign acc_next = (carry || ovf) ? '1 : add_full[ACC_W-1:0];
`else
  assign acc_next = acc + mul_ext;
  assign ovf      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_start <= 1'b0;
      sum       <= '0;
      sum_valid <= 1'b0;
      in_ready  <= 1'b0;
`ifdef DOT_PRODUCT_SATURATE_EN
      ovf       <= 1'b0;
`endif
    end else if (clr) begin
      // mul_a, mul_b and sum deliberately keep their values
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      mul_start <= 1'b0;
      sum_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef DOT_PRODUCT_SATURATE_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          // in_ready is low for the first cycle after reset release
          if (in_valid && in_ready) begin
            mul_a     <= in_a;
            mul_b     <= in_b;
            mul_start <= 1'b1;
            in_ready  <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          mul_start <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          if (mul_ready) begin
            acc <= acc_next;
`ifdef DOT_PRODUCT_SATURATE_EN
            if (carry) ovf <= 1'b1;
`endif
            if (last) begin
              sum       <= acc_next;
              sum_valid <= 1'b1;
              state     <= DONE;
            end else begin
              cnt      <= cnt + CNT_W'(1);
              in_ready <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        DONE: begin
          if (sum_ready) begin
            acc       <= '0;
            cnt       <= '0;
            sum_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
`ifdef DOT_PRODUCT_SATURATE_EN
            ovf       <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// tb_dot_product_ctrl
//   Directed bench for dot_product_ctrl. Two instances share one stimulus:
//   dut uses the default ACC_W=18, and dut16 uses ACC_W=16 for the overflow case.
//   Each instance drives its own 8-cycle multiplier model.
module tb_dot_product_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [7:0]  in_a, in_b;
  logic        sum_ready;

  logic        in_ready, mul_start, sum_valid, ovf;
  logic [7:0]  mul_a, mul_b;
  logic        mul_ready = 1'b0;
  logic [15:0] mul_m = '0;
  logic [17:0] sum;

  logic        in_ready16, mul_start16, sum_valid16, ovf16;
  logic [7:0]  mul_a16, mul_b16;
  logic        mul_ready16 = 1'b0;
  logic [15:0] mul_m16 = '0;
  logic [15:0] sum16;

  int checks = 0;
  int errors = 0;
  int starts = 0;

  always #5 clk = ~clk;

  dot_product_ctrl #(.W(8), .LEN(4), .ACC_W(18)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_ready(mul_ready), .mul_m(mul_m),
    .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready), .ovf(ovf)
  );

  dot_product_ctrl #(.W(8), .LEN(4), .ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a16), .mul_b(mul_b16), .mul_start(mul_start16),
    .mul_ready(mul_ready16), .mul_m(mul_m16),
    .sum(sum16), .sum_valid(sum_valid16), .sum_ready(sum_ready), .ovf(ovf16)
  );

  // Multiplier models: product valid 8 edges after the start edge.
  // They are not reset, so results that are still in flight after an abort
  // show up late.
  logic [3:0] cd = '0, cd16 = '0;
  logic [7:0] ma = '0, mb = '0, ma16 = '0, mb16 = '0;

  always @(posedge clk) begin
    if (mul_start) begin
      cd <= 4'd8; mul_ready <= 1'b0; ma <= mul_a; mb <= mul_b;
    end else if (cd != 0) begin
      cd <= cd - 4'd1;
      if (cd == 4'd1) begin mul_ready <= 1'b1; mul_m <= ma * mb; end
    end
  end

  always @(posedge clk) begin
    if (mul_start16) begin
      cd16 <= 4'd8; mul_ready16 <= 1'b0; ma16 <= mul_a16; mb16 <= mul_b16;
    end else if (cd16 != 0) begin
      cd16 <= cd16 - 4'd1;
      if (cd16 == 4'd1) begin mul_ready16 <= 1'b1; mul_m16 <= ma16 * mb16; end
    end
  end

  always @(posedge clk) if (mul_start) starts <= starts + 1;

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, output bit ok);
    wait_ready(ok);
    if (ok) begin
      in_a = a; in_b = b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_vec(input logic [7:0] a, input logic [7:0] b, output bit ok);
    bit one;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_pair(a, b, one);
      ok &= one;
    end
  endtask

  task automatic wait_sum(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sum_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic accept_sum();
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
  endtask

  // ------------------------------ tests ------------------------------
  task automatic test_reset();
    int base;
    rst_n = 1'b0; clr = 1'b0; sum_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55;
    repeat (3) @(negedge clk);
    base = starts;
    checks++;
    if ({in_ready, mul_start, sum_valid, ovf} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000", {in_ready, mul_start, sum_valid, ovf});
    end
    checks++;
    if (sum !== 18'd0) begin errors++; $display("FAIL reset_sum: got %0d want 0", sum); end
    checks++;
    if ({mul_a, mul_b} !== 16'h0000) begin
      errors++; $display("FAIL reset_operands: got %h want 0000", {mul_a, mul_b});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (starts - base !== 0) begin
      errors++; $display("FAIL reset_no_start: got %0d starts want 0", starts - base);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    in_a = 8'd3; in_b = 8'd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({mul_start, in_ready, mul_a, mul_b} !== {1'b1, 1'b0, 8'd3, 8'd4}) begin
      errors++;
      $display("FAIL start_pulse: got start=%b rdy=%b a=%0d b=%0d want 1 0 3 4",
               mul_start, in_ready, mul_a, mul_b);
    end
    @(negedge clk);
    checks++;
    if (mul_start !== 1'b0 || starts - base !== 1) begin
      errors++;
      $display("FAIL start_one_cycle: got start=%b count=%0d want 0 1", mul_start, starts - base);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int base;
    bit ok, ok2;
    base = starts;
    send_pair(8'd3, 8'd4, ok);
    send_pair(8'd5, 8'd6, ok2);  ok &= ok2;
    send_pair(8'd7, 8'd8, ok2);  ok &= ok2;
    send_pair(8'd9, 8'd10, ok2); ok &= ok2;
    wait_sum(ok2); ok &= ok2;
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: got handshake timeout want none"); end
    checks++;
    if (sum !== 18'd188 || sum_valid !== 1'b1) begin
      errors++; $display("FAIL basic_sum: got %0d valid=%b want 188 valid=1", sum, sum_valid);
    end
    checks++;
    if (starts - base !== 4) begin
      errors++; $display("FAIL basic_starts: got %0d want 4", starts - base);
    end
    checks++;
    if (ovf !== 1'b0 || sum16 !== 16'd188) begin
      errors++; $display("FAIL basic_ovf_sum16: got ovf=%b sum16=%0d want 0 188", ovf, sum16);
    end
  endtask

  task automatic test_backpressure();
    int base, bad;
    bit ok, ok2;
    base = starts; bad = 0;
    sum_ready = 1'b0;
    in_a = 8'd9; in_b = 8'd9; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sum !== 18'd188 || sum_valid !== 1'b1 || in_ready !== 1'b0 || mul_start !== 1'b0)
        bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad); end
    checks++;
    if (starts - base !== 0) begin
      errors++; $display("FAIL hold_no_start: got %0d starts want 0", starts - base);
    end
    accept_sum();
    checks++;
    if (sum_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 18'd188) begin
      errors++;
      $display("FAIL accept: got valid=%b rdy=%b sum=%0d want 0 1 188", sum_valid, in_ready, sum);
    end
    send_vec(8'd1, 8'd1, ok);
    wait_sum(ok2); ok &= ok2;
    checks++;
    if (!ok || sum !== 18'd4) begin
      errors++; $display("FAIL ones_sum: got %0d ok=%b want 4 ok=1", sum, ok);
    end
    accept_sum();
  endtask

  task automatic test_max();
    bit ok, ok2;
    logic [15:0] exp16;
    logic        expo16;
`ifdef DOT_PRODUCT_SATURATE_EN
    exp16 = 16'd65535; expo16 = 1'b1;
`else
    exp16 = 16'd63492; expo16 = 1'b0;
`endif
    send_vec(8'd255, 8'd255, ok);
    wait_sum(ok2); ok &= ok2;
    checks++;
    if (!ok || sum !== 18'd260100 || ovf !== 1'b0) begin
      errors++; $display("FAIL max_sum18: got %0d ovf=%b want 260100 ovf=0", sum, ovf);
    end
    checks++;
    if (sum_valid16 !== 1'b1 || sum16 !== exp16 || ovf16 !== expo16) begin
      errors++;
      $display("FAIL max_sum16: got %0d ovf=%b valid=%b want %0d ovf=%b valid=1",
               sum16, ovf16, sum_valid16, exp16, expo16);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (sum16 !== exp16 || ovf16 !== expo16) begin
      errors++; $display("FAIL max_hold16: got %0d ovf=%b want %0d ovf=%b", sum16, ovf16, exp16, expo16);
    end
    accept_sum();
    checks++;
    if (ovf16 !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b want 0", ovf16); end
  endtask

  task automatic test_clr();
    int base;
    bit ok, ok2;
    wait_ready(ok);
    base = starts;
    in_a = 8'd1; in_b = 8'd1; in_valid = 1'b1; clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clr = 1'b0;
    checks++;
    if (!ok || in_ready !== 1'b1 || mul_start !== 1'b0) begin
      errors++; $display("FAIL clr_wins: got rdy=%b start=%b want 1 0", in_ready, mul_start);
    end
    @(negedge clk);
    checks++;
    if (starts - base !== 0) begin
      errors++; $display("FAIL clr_no_accept: got %0d starts want 0", starts - base);
    end
    send_pair(8'd7, 8'd7, ok);
    send_pair(8'd7, 8'd7, ok2); ok &= ok2;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || sum_valid !== 1'b0) begin
      errors++; $display("FAIL clr_idle: got rdy=%b valid=%b want 1 0", in_ready, sum_valid);
    end
    send_vec(8'd2, 8'd2, ok2); ok &= ok2;
    wait_sum(ok2); ok &= ok2;
    checks++;
    if (!ok || sum !== 18'd16) begin
      errors++; $display("FAIL clr_resume: got %0d ok=%b want 16 ok=1", sum, ok);
    end
    accept_sum();
  endtask

  task automatic test_rst_abort();
    bit ok, ok2;
    send_pair(8'd7, 8'd7, ok);
    send_pair(8'd7, 8'd7, ok2); ok &= ok2;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, mul_start, sum_valid} !== 3'b000 || sum !== 18'd0) begin
      errors++;
      $display("FAIL rst_mid: got flags=%b sum=%0d want 000 0", {in_ready, mul_start, sum_valid}, sum);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);  // let the stale product arrive while idle
    send_vec(8'd2, 8'd2, ok2); ok &= ok2;
    wait_sum(ok2); ok &= ok2;
    checks++;
    if (!ok || sum !== 18'd16) begin
      errors++; $display("FAIL rst_resume: got %0d ok=%b want 16 ok=1", sum, ok);
    end
    accept_sum();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; sum_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_max();
    test_clr();
    test_rst_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
